// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, resolves J-type jumps locally, accepts
// branch redirects from downstream and presents a registered IF/ID bundle.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'h3F,
  parameter logic [5:0]  JUMP_OPCODE = 6'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_pc4,
  input  logic [15:0] br_imm16,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_plus4;
  logic [31:0] instr_nxt, pc4_nxt, count_nxt;
  logic        valid_nxt;
  logic [5:0]  opcode;

  function automatic logic [31:0] branch_target(input logic [31:0] pc4,
                                                input logic [15:0] imm16);
    logic signed [31:0] offset;
    offset = $signed({{14{imm16[15]}}, imm16, 2'b00});
    return $unsigned($signed(pc4) + offset);
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opcode    = imem_rdata[31:26];

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = ifid_instr;
    pc4_nxt   = ifid_pc4;
    valid_nxt = ifid_valid;
    count_nxt = fetch_count;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (br_take) begin
          pc_nxt    = branch_target(br_pc4, br_imm16);
          instr_nxt = '0;
          pc4_nxt   = '0;
          valid_nxt = 1'b0;
        end else if (!stall) begin
          instr_nxt = imem_rdata;
          pc4_nxt   = pc_plus4;
          valid_nxt = 1'b1;
          count_nxt = fetch_count + 32'd1;
          if (opcode == JUMP_OPCODE)
            pc_nxt = jump_target(pc_plus4, imem_rdata);
          else if (opcode == HALT_OPCODE)
            state_nxt = HALT;
          else
            pc_nxt = pc_plus4;
        end
      end
      HALT: begin
        // A taken branch here means the halt was on the wrong path.
        if (br_take) begin
          pc_nxt    = branch_target(br_pc4, br_imm16);
          instr_nxt = '0;
          pc4_nxt   = '0;
          valid_nxt = 1'b0;
          state_nxt = RUN;
        end else if (!stall) begin
          instr_nxt = '0;
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // IF/ID boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pc4    <= '0;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      ifid_instr  <= instr_nxt;
      ifid_pc4    <= pc4_nxt;
      ifid_valid  <= valid_nxt;
      halted      <= (state_nxt == HALT);
      fetch_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: a behavioural model queues the expected
// state for each edge and the popped entry is compared after the edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, br_take;
  logic [31:0] br_pc4;
  logic [15:0] br_imm16;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_instr, ifid_pc4, fetch_count;
  logic        ifid_valid, halted;

  logic        stall2 = 1'b0, br_take2 = 1'b0;
  logic [31:0] br_pc4_2 = '0;
  logic [15:0] br_imm16_2 = '0;
  logic [31:0] imem_addr2, imem_rdata2, ifid_instr2, ifid_pc4_2, fetch_count2;
  logic        ifid_valid2, halted2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          st;      // 0 boot, 1 run, 2 halt
    logic [31:0] pc, instr, pc4, cnt;
    logic        valid, halted;
  } exp_t;

  exp_t m;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h20:  return 32'h0800_0040;
      32'h30:  return 32'hFC00_0000;
      default: return 32'h2001_0005;
    endcase
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = 32'h2001_0005;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_take(br_take),
    .br_pc4(br_pc4), .br_imm16(br_imm16), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_count(fetch_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall2), .br_take(br_take2),
    .br_pc4(br_pc4_2), .br_imm16(br_imm16_2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .ifid_instr(ifid_instr2), .ifid_pc4(ifid_pc4_2),
    .ifid_valid(ifid_valid2), .halted(halted2), .fetch_count(fetch_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model_reset();
    exp_t r;
    r.st = 0; r.pc = 32'h0; r.instr = '0; r.pc4 = '0; r.cnt = '0;
    r.valid = 1'b0; r.halted = 1'b0;
    return r;
  endfunction

  function automatic exp_t model_next(input exp_t c, input logic bt, input logic stl,
                                      input logic [31:0] bpc4, input logic [15:0] imm);
    exp_t n = c;
    logic [31:0] w = mem_word(c.pc);
    logic [31:0] tgt = bpc4 + {{14{imm[15]}}, imm, 2'b00};
    if (c.st == 0) begin
      n.st = 1;
    end else if (bt) begin
      n.pc = tgt; n.instr = '0; n.pc4 = '0; n.valid = 1'b0; n.st = 1;
    end else if (stl) begin
      n = c;
    end else if (c.st == 2) begin
      n.instr = '0; n.valid = 1'b0;
    end else begin
      n.instr = w; n.pc4 = c.pc + 4; n.valid = 1'b1; n.cnt = c.cnt + 1;
      if (w[31:26] == 6'h02)      n.pc = {n.pc4[31:28], w[25:0], 2'b00};
      else if (w[31:26] == 6'h3F) n.st = 2;
      else                        n.pc = c.pc + 4;
    end
    n.halted = (n.st == 2);
    return n;
  endfunction

  task automatic step();
    exp_t e;
    sb_q.push_back(model_next(m, br_take, stall, br_pc4, br_imm16));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check("sb_addr",   imem_addr,   e.pc);
      check("sb_instr",  ifid_instr,  e.instr);
      check("sb_pc4",    ifid_pc4,    e.pc4);
      check("sb_valid",  {31'b0, ifid_valid}, {31'b0, e.valid});
      check("sb_count",  fetch_count, e.cnt);
      check("sb_halted", {31'b0, halted}, {31'b0, e.halted});
      m = e;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_take = 1'b0; br_pc4 = '0; br_imm16 = '0;
    m = model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, ifid_valid}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    step();
    check("boot_bubble", {31'b0, ifid_valid}, 32'd0);
    step();
    check("first_instr", ifid_instr, 32'h2001_0005);
    check("first_pc4",   ifid_pc4, 32'h4);
    check("first_addr",  imem_addr, 32'h4);
    check("first_count", fetch_count, 32'd1);
    check("wrap_pc4",    ifid_pc4_2, 32'h0);
    check("wrap_addr",   imem_addr2, 32'h0);

    step(); step();
    check("run_addr", imem_addr, 32'd12);
    stall = 1'b1;
    step(); step();
    check("stall_addr",  imem_addr, 32'd12);
    check("stall_count", fetch_count, 32'd3);
    check("stall_pc4",   ifid_pc4, 32'd12);
    stall = 1'b0;
    step();
    check("unstall_addr", imem_addr, 32'd16);

    br_take = 1'b1; br_pc4 = 32'h10; br_imm16 = 16'hFFFE; stall = 1'b1;
    step();
    br_take = 1'b0; stall = 1'b0;
    check("br_addr",  imem_addr, 32'h8);
    check("br_valid", {31'b0, ifid_valid}, 32'd0);
    check("br_count", fetch_count, 32'd4);

    for (int i = 0; i < 6; i++) step();
    check("pre_jump_addr", imem_addr, 32'h20);
    step();
    check("jump_instr", ifid_instr, 32'h0800_0040);
    check("jump_pc4",   ifid_pc4, 32'h24);
    check("jump_addr",  imem_addr, 32'h100);

    br_take = 1'b1; br_pc4 = 32'h30; br_imm16 = 16'h0;
    step();
    br_take = 1'b0;
    check("to_halt_addr", imem_addr, 32'h30);
    step();
    check("halt_instr",  ifid_instr, 32'hFC00_0000);
    check("halt_valid",  {31'b0, ifid_valid}, 32'd1);
    check("halt_flag",   {31'b0, halted}, 32'd1);
    step();
    check("halt_bubble", {31'b0, ifid_valid}, 32'd0);
    check("halt_addr",   imem_addr, 32'h30);
    stall = 1'b1;
    step();
    stall = 1'b0;
    step();
    br_take = 1'b1; br_pc4 = 32'h2C; br_imm16 = 16'h1;
    step();
    br_take = 1'b0;
    check("recover_addr",   imem_addr, 32'h30);
    check("recover_halted", {31'b0, halted}, 32'd0);

    // pc is at the halt word again: a branch in the same cycle must discard it
    br_take = 1'b1; br_pc4 = 32'h40; br_imm16 = 16'h0;
    step();
    br_take = 1'b0;
    check("br_over_halt_addr",   imem_addr, 32'h40);
    check("br_over_halt_halted", {31'b0, halted}, 32'd0);

    for (int i = 0; i < 24; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      br_take  = ($urandom_range(0, 4) == 0);
      br_pc4   = 32'($urandom_range(0, 31)) << 2;
      br_imm16 = 16'($urandom_range(0, 7));
      step();
    end
    stall = 1'b0; br_take = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("arst_addr",   imem_addr, 32'h0);
    check("arst_valid",  {31'b0, ifid_valid}, 32'd0);
    check("arst_instr",  ifid_instr, 32'h0);
    check("arst_pc4",    ifid_pc4, 32'h0);
    check("arst_count",  fetch_count, 32'd0);
    check("arst_halted", {31'b0, halted}, 32'd0);
    #1 rst_n = 1'b1;
    m = model_reset();
    step();
    check("arst_boot_bubble", {31'b0, ifid_valid}, 32'd0);
    step();
    check("arst_first_pc4",   ifid_pc4, 32'h4);
    check("arst_wrap_pc4",    ifid_pc4_2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
